// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter sequencing start, sequential fetch, branches, stalls and halt with a saturating retire count
module fetch_sequencer #(
  parameter logic [8:0] HALT_INSTR = 9'b111111111,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       start_addr,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             branch_abs,
  input  logic [7:0]       branch_target,
  input  logic [8:0]       instr_in,
  output logic [7:0]       pc,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [7:0] pc_nx;
  logic [CNT_W-1:0] cnt_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      instr_count <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    cnt_nx = instr_count;
    if (state != RUN) begin
      if (start) begin
        state_nx = RUN;
        pc_nx = start_addr;
        cnt_nx = '0;
      end
    end else if (!stall) begin
      if (instr_in == HALT_INSTR) state_nx = HALTED;
      else begin
        pc_nx = !branch_taken ? pc + 8'd1 : branch_abs ? branch_target : pc + branch_target;
        cnt_nx = &instr_count ? instr_count : instr_count + CNT_W'(1);
      end
    end
  end
  assign busy = state == RUN;
  assign instr_valid = busy;
  assign done = state == HALTED;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [8:0] HALT = 9'h1FF;
  logic clk = 0;
  logic reset, start, stall, branch_taken, branch_abs;
  logic [7:0] start_addr, branch_target, pc;
  logic [8:0] instr_in;
  logic instr_valid, busy, done;
  logic [CW-1:0] instr_count;
  logic [8:0] rom [256];
  int checks = 0, failures = 0;
  int m_pc = 0, m_cnt = 0;
  bit m_run = 0, m_halt = 0;
  always #5 clk = ~clk;
  assign instr_in = rom[pc];
  fetch_sequencer #(.HALT_INSTR(HALT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stall(stall),
    .branch_taken(branch_taken), .branch_abs(branch_abs), .branch_target(branch_target),
    .instr_in(instr_in), .pc(pc), .instr_valid(instr_valid), .busy(busy), .done(done),
    .instr_count(instr_count)
  );
  task automatic drive(input bit r, input bit s, input int sa, input bit st, input bit bt, input bit ba, input int tg);
    reset = r;
    start = s;
    start_addr = 8'(sa);
    stall = st;
    branch_taken = bt;
    branch_abs = ba;
    branch_target = 8'(tg);
  endtask
  task automatic step;
    if (reset) begin
      m_run = 0;
      m_halt = 0;
      m_pc = 0;
      m_cnt = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1;
        m_halt = 0;
        m_pc = int'(start_addr);
        m_cnt = 0;
      end
    end else if (!stall) begin
      if (rom[m_pc] == HALT) begin
        m_run = 0;
        m_halt = 1;
      end else begin
        if (!branch_taken) m_pc = (m_pc + 1) % 256;
        else if (branch_abs) m_pc = int'(branch_target);
        else m_pc = (m_pc + 256 + (branch_target < 128 ? int'(branch_target) : int'(branch_target) - 256)) % 256;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic fill_rom(input int halt_odds);
    for (int i = 0; i < 256; i++)
      rom[i] = (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) ? HALT : 9'($urandom_range(0, 510));
  endtask
  task automatic test_reset;
    drive(1, 1, 'h77, 0, 1, 1, 'h33);
    step();
    checks++;
    if (pc !== 8'h00 || busy !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0 || instr_count !== '0) begin
      failures++;
      $display("FAIL reset pc=%h busy=%b valid=%b done=%b cnt=%0d required pc=00 busy=0 valid=0 done=0 cnt=0", pc, busy, instr_valid, done, instr_count);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
      step();
      checks++;
      if (pc !== 8'(m_pc) || busy !== m_run || instr_valid !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL idle_hold pc=%h busy=%b done=%b cnt=%0d required pc=%h busy=%b done=%b cnt=%0d", pc, busy, done, instr_count, m_pc[7:0], m_run, m_halt, m_cnt);
      end
    end
  endtask
  task automatic test_sequential;
    fill_rom(0);
    rom[8'h14] = HALT;
    drive(0, 1, 'h10, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pc !== 8'(m_pc) || busy !== m_run || instr_valid !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL seq i=%0d pc=%h busy=%b done=%b cnt=%0d required pc=%h busy=%b done=%b cnt=%0d", i, pc, busy, done, instr_count, m_pc[7:0], m_run, m_halt, m_cnt);
      end
      drive(0, 0, $urandom_range(0, 255), 0, 0, $urandom_range(0, 1), $urandom_range(0, 255));
      step();
    end
    checks++;
    if (pc !== 8'h14 || done !== 1'b1 || busy !== 1'b0 || instr_count !== CW'(4)) begin
      failures++;
      $display("FAIL seq_halt pc=%h done=%b busy=%b cnt=%0d required pc=14 done=1 busy=0 cnt=4", pc, done, busy, instr_count);
    end
  endtask
  task automatic test_branches;
    int bt [6] = '{1, 1, 1, 1, 0, 1};
    int ba [6] = '{1, 0, 1, 0, 1, 0};
    int tg [6] = '{'h05, 'hFC, 'hFE, 'h03, 'h44, 'h80};
    int ex [6] = '{'h05, 'h01, 'hFE, 'h01, 'h02, 'h82};
    fill_rom(0);
    drive(0, 1, 'h20, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, bt[i], ba[i], tg[i]);
      step();
      checks++;
      if (pc !== 8'(ex[i]) || pc !== 8'(m_pc) || busy !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL branch i=%0d pc=%h cnt=%0d required pc=%h cnt=%0d", i, pc, instr_count, ex[i][7:0], m_cnt);
      end
    end
  endtask
  task automatic test_wrap;
    drive(0, 0, 0, 0, 1, 1, 'hFD);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 255));
      step();
      checks++;
      if (pc !== 8'(m_pc) || busy !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL wrap i=%0d pc=%h cnt=%0d required pc=%h cnt=%0d", i, pc, instr_count, m_pc[7:0], m_cnt);
      end
    end
  endtask
  task automatic test_stall;
    rom[8'h30] = HALT;
    drive(0, 0, 0, 0, 1, 1, 'h30);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, $urandom_range(0, 1), 'h66, 1, 1, 1, 'h99);
      step();
      checks++;
      if (pc !== 8'h30 || done !== 1'b0 || busy !== 1'b1 || pc !== 8'(m_pc) || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL stall i=%0d pc=%h done=%b busy=%b cnt=%0d required pc=30 done=0 busy=1 cnt=%0d", i, pc, done, busy, instr_count, m_cnt);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 8'h30 || instr_count !== CW'(m_cnt)) begin
      failures++;
      $display("FAIL stall_release pc=%h done=%b busy=%b cnt=%0d required pc=30 done=1 busy=0 cnt=%0d", pc, done, busy, instr_count, m_cnt);
    end
  endtask
  task automatic test_halt_branch;
    fill_rom(0);
    rom[8'h50] = HALT;
    drive(0, 1, 'h48, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 'h99, 0, 0, 0, 0);
      step();
      checks++;
      if (pc !== 8'(m_pc) || busy !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL start_in_run i=%0d pc=%h cnt=%0d required pc=%h cnt=%0d", i, pc, instr_count, m_pc[7:0], m_cnt);
      end
    end
    drive(0, 0, 0, 0, 1, 1, 'h50);
    step();
    drive(0, 0, 0, 0, 1, 1, 'h10);
    step();
    checks++;
    if (pc !== 8'h50 || done !== 1'b1 || busy !== 1'b0 || instr_count !== CW'(m_cnt)) begin
      failures++;
      $display("FAIL halt_vs_branch pc=%h done=%b busy=%b cnt=%0d required pc=50 done=1 busy=0 cnt=%0d", pc, done, busy, instr_count, m_cnt);
    end
    drive(0, 1, 'h40, 0, 0, 0, 0);
    step();
    checks++;
    if (pc !== 8'h40 || done !== 1'b0 || busy !== 1'b1 || instr_count !== '0) begin
      failures++;
      $display("FAIL restart pc=%h done=%b busy=%b cnt=%0d required pc=40 done=0 busy=1 cnt=0", pc, done, busy, instr_count);
    end
  endtask
  task automatic test_reset_midrun;
    fill_rom(0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 'h1E, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (pc !== 8'h25 || instr_count !== CW'(7) || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset pc=%h cnt=%0d busy=%b required pc=25 cnt=7 busy=1", pc, instr_count, busy);
    end
    drive(1, 1, 'h60, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (pc !== 8'h00 || instr_count !== '0 || busy !== 1'b0 || done !== 1'b0 || pc !== 8'(m_pc)) begin
      failures++;
      $display("FAIL reset_midrun pc=%h cnt=%0d busy=%b done=%b required pc=00 cnt=0 busy=0 done=0", pc, instr_count, busy, done);
    end
  endtask
  task automatic test_saturate;
    fill_rom(0);
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CMAX + 20; i++) step();
    checks++;
    if (instr_count !== CW'(CMAX) || instr_count !== CW'(m_cnt) || pc !== 8'(m_pc)) begin
      failures++;
      $display("FAIL saturate cnt=%0d pc=%h required cnt=%0d pc=%h", instr_count, pc, CMAX, m_pc[7:0]);
    end
  endtask
  task automatic test_random;
    fill_rom(20);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 255));
      step();
      checks++;
      if (pc !== 8'(m_pc) || busy !== m_run || instr_valid !== m_run || done !== m_halt || instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL random i=%0d pc=%h busy=%b done=%b cnt=%0d required pc=%h busy=%b done=%b cnt=%0d", i, pc, busy, done, instr_count, m_pc[7:0], m_run, m_halt, m_cnt);
      end
    end
  endtask
  initial begin
    fill_rom(0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    test_reset();
    test_sequential();
    test_branches();
    test_wrap();
    test_stall();
    test_halt_branch();
    test_reset_midrun();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter controller for the Beeth9 fetch stage. It owns the 8-bit instruction address that drives the combinational 256×9 instruction ROM. It sequences execution from a start handshake through sequential fetch, taken branches and stalls until a halt instruction is fetched. It then reports completion and a retired-instruction count to the testbench and top level.

## Interface
Parameters:
- HALT_INSTR, 9'b111111111: encoding of the halt instruction.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: single system clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin execution at start_addr; sampled in IDLE or HALTED only.
- start_addr, input, 8: entry address, latched with start.
- stall, input, 1: hold the current PC; the instruction is not retired this cycle.
- branch_taken, input, 1: redirect the PC this cycle.
- branch_abs, input, 1: 1 = absolute target; 0 = PC-relative signed offset.
- branch_target, input, 8: absolute address, or two's-complement offset.
- instr_in, input, 9: instruction currently read from ROM at pc.
- pc, output, 8: instruction address to ROM.
- instr_valid, output, 1: instr_in is a live instruction (state RUN).
- busy, output, 1: state == RUN.
- done, output, 1: state == HALTED.
- instr_count, output, CNT_W: instructions retired since the last start.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- IDLE: start=1 -> RUN; pc <= start_addr; instr_count <= 0. Otherwise everything holds.
- RUN, per cycle, priority high to low:
  1. stall=1: pc, state and count hold. A halt or branch in the same cycle is ignored and re-evaluated next cycle.
  2. instr_in == HALT_INSTR: -> HALTED; pc holds on the halt address. Halt is not counted. branch_taken is ignored.
  3. branch_taken=1: pc <= branch_target if branch_abs, else pc + sign-extended branch_target (mod 256). Count +1.
  4. Otherwise: pc <= pc + 1 (mod 256; 255 wraps to 0). Count +1.
- start is ignored while in RUN.
- HALTED: done=1, pc holds. start=1 -> RUN, pc <= start_addr, count <= 0, done drops the next cycle.
- instr_count saturates at all-ones; it never wraps.
- branch_abs and branch_target are don't-care when branch_taken=0.
- instr_valid = busy. Outputs are registered state or direct decodes of state. No combinational path from inputs to pc.

## Timing
- Reset values:
  - state = IDLE
  - pc = 0
  - instr_count = 0
  - busy = instr_valid = done = 0
- A reset asserted mid-RUN or in HALTED returns to these values on the next edge. A start in the same cycle as reset is dropped.
- Start latency: start sampled at edge N; at N+1, busy=1 and pc=start_addr; the first instruction is valid during cycle N+1.
- One instruction per non-stalled RUN cycle. ROM read is combinational, so instr_in corresponds to the pc of the same cycle.
- Branch latency: a taken branch sampled at edge N; pc=target from N+1. No delay slot.
- Halt: halt visible at edge N; done=1 and busy=0 from N+1. pc = halt address; instr_count excludes the halt.
- Restart from HALTED: start at edge N; done=0, busy=1, pc=start_addr at N+1.

## Test plan
- Reset then start with start_addr=0x10. Run 0x10–0x13 sequential, with HALT_INSTR at 0x14. Expect pc 0x10,0x11,0x12,0x13,0x14 on consecutive cycles, then done=1, pc=0x14, instr_count=4.
- Branches at pc=0x20:
  - Absolute, target 0x05: next pc=0x05.
  - Relative, offset 0xFC at pc=0x05: next pc=0x01.
  - Relative, offset 0x03 at pc=0xFE: next pc=0x01 (wrap).
- Sequential run across 0xFF: next pc=0x00, count keeps incrementing.
- Stall held 3 cycles while instr_in=HALT_INSTR at pc=0x30: pc stays 0x30, done=0, count unchanged. Release stall: done=1 on the next cycle.
- Halt and branch_taken in the same cycle: halt wins, pc stays. start pulse during RUN: ignored. start while HALTED with start_addr=0x40: count cleared, pc=0x40, done=0 next cycle.
- Reset asserted mid-RUN at pc=0x25 with count=7: next cycle state IDLE, pc=0, count=0, busy=done=0. start in the same cycle as reset: no effect.
